fir_tdm_scheduler: RTL and testbench
====================================

// Module: fir_tdm_scheduler
// PURPOSE
//   Time-division scheduler that shares one multiply-accumulate FIR engine among NCH ADC channels.
//   Each channel has its own trigger, sample latch and N-deep history.
//   A round-robin arbiter grants one pending channel at a time.
//   A sequencer then steps the MAC through all N taps and posts a tagged, scaled result.
//   Sits between the ADC capture front-ends and downstream demod/loop logic.
//   Replaces one FIR instance per channel.
// PARAMETERS
//   NCH       4        number of channels sharing the engine (>=2)
//   N         32       taps per channel
//   WIDTH     14       signed ADC sample width
//   SHIFT     16       arithmetic right shift applied to accumulator before output
//   COEFF_SET N32FC5   signed [15:0] x32: -54,-64,-82,-97,-93,-47,66,266,562,951,1412,1909,2396,
//                      2821,3136,3304, then the same 16 values mirrored (sum 32772)
// PORTS
//   clk        in   1            clock
//   n_rst      in   1            asynchronous, active-low reset
//   i_trig     in   NCH          per-channel sample strobe, 1 cycle
//   din        in   NCH*WIDTH    signed samples; ch c at [c*WIDTH +: WIDTH]
//   i_clr_ovr  in   1            clear all sticky overrun flags
//   o_busy     out  1            engine not IDLE
//   o_valid    out  1            result strobe, 1 cycle
//   o_ch       out  $clog2(NCH)  channel tag of dout, held until next o_valid
//   dout       out  32           signed filtered result
//   o_overrun  out  NCH          sticky: sample replaced before it was serviced
// BEHAVIOUR
//   Reset values (async): all outputs 0; pend, latches and histories 0; state IDLE; rr pointer 0.
//   Capture: at any edge with i_trig[c]=1, din[c] goes into lat[c] and pend[c] is set.
//     - If pend[c] is already 1 and c is not granted at that edge: lat[c] is overwritten and o_overrun[c] is set.
//     - Trigger on a channel being granted at the same edge: the grant takes the old lat[c]; pend[c] stays 1 with the new sample; no overrun.
//     - o_overrun: set wins over i_clr_ovr at the same edge.
//   Arbiter: acts in IDLE only.
//     - Picks the first pend bit searching from (last_grant+1) mod NCH; the search starts at ch0 after reset.
//     - On grant: clears pend, latches sample and channel, moves to LOAD.
//   FSM states:
//     - IDLE  -> LOAD when any pend bit is set.
//     - LOAD  (1 cycle): hist[ch] shifts; lat becomes tap0 and the oldest entry is dropped; acc<=0; k<=0; -> MAC.
//     - MAC   (N cycles): acc += hist[ch][k]*COEFF_SET[k]; k++; -> OUT after k=N-1.
//     - OUT   (1 cycle): dout<=acc>>>SHIFT (sign-kept, truncated to 32); o_ch<=ch; o_valid<=1; -> IDLE.
//   Arithmetic:
//     - y = sum_{k=0..N-1} c[k]*x[n-k], where tap0 is the newest sample.
//     - Product is WIDTH+16 bits signed; acc is WIDTH+16+$clog2(N) bits; no saturation.
//   Latency and throughput:
//     - Uncontended: trig sampled at edge 0 -> grant at edge 1 -> o_valid high after edge N+3 (35).
//     - Back-to-back grants are N+3 cycles apart; max aggregate trigger rate is 1/(N+3) per clk.
//   Histories are fully independent per channel; an idle channel's history is frozen.
//   Reset mid-job aborts it: no o_valid, histories zeroed, pending samples lost.
// TESTING
//   1 Impulse: ch0 din=1000 once, then 0s, trig every 40 clk
//     -> outputs (1000*c[k])>>>16 for k=0..31, e.g. -1 at k=0, 50 at k=15; then 0.
//   2 DC: ch1 din=8191 for 40 triggers -> after the 32nd trigger dout=4095 steady, o_ch=1.
//   3 Contention: i_trig=4'b1111 at edge 0
//     -> o_valid after edges 35,70,105,140 with o_ch=0,1,2,3; o_busy high throughout.
//   4 Overrun: ch2 triggered twice (din=100, then 200) while ch0 runs
//     -> o_overrun[2]=1; the ch2 result uses 200 only; i_clr_ovr -> 0.
//   5 Reset mid-MAC: pulse n_rst low at cycle 10 of a ch3 job
//     -> no o_valid, all outputs 0; a following impulse reproduces test 1 exactly.
//   6 Isolation: impulse on ch3 interleaved with zeros on ch0 -> every ch0 result is 0.

Source files
------------

// File: rtl/fir_tdm_scheduler.sv
// fir_tdm_scheduler: round-robin sharing of one 32-tap MAC FIR engine among NCH ADC channels,
// each channel with its own trigger, sample latch, N-deep history and sticky overrun flag.
module fir_tdm_scheduler #(
  parameter int NCH   = 4,
  parameter int N     = 32,
  parameter int WIDTH = 14,
  parameter int SHIFT = 16
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [NCH-1:0]           i_trig,
  input  logic [NCH*WIDTH-1:0]     din,
  input  logic                     i_clr_ovr,
  output logic                     o_busy,
  output logic                     o_valid,
  output logic [$clog2(NCH)-1:0]   o_ch,
  output logic [31:0]              dout,
  output logic [NCH-1:0]           o_overrun
);
  localparam int CW = $clog2(NCH);
  localparam int KW = $clog2(N);
  localparam int PW = WIDTH + 16;
  localparam int AW = PW + KW;
  localparam logic signed [15:0] COEFF [N] = '{
    -16'sd54, -16'sd64, -16'sd82, -16'sd97, -16'sd93, -16'sd47, 16'sd66, 16'sd266,
    16'sd562, 16'sd951, 16'sd1412, 16'sd1909, 16'sd2396, 16'sd2821, 16'sd3136, 16'sd3304,
    16'sd3304, 16'sd3136, 16'sd2821, 16'sd2396, 16'sd1909, 16'sd1412, 16'sd951, 16'sd562,
    16'sd266, 16'sd66, -16'sd47, -16'sd93, -16'sd97, -16'sd82, -16'sd64, -16'sd54};

  typedef enum logic [1:0] {IDLE, LOAD, MAC, OUT} state_t;
  state_t r_state, w_next;

  logic [NCH-1:0]          r_pend, w_gnt_oh;
  logic signed [WIDTH-1:0] r_lat [NCH];
  logic signed [WIDTH-1:0] r_hist [NCH][N];
  logic signed [WIDTH-1:0] r_smp;
  logic [CW-1:0]           r_ch, r_ptr, w_gnt, w_idx;
  logic [KW-1:0]           r_k;
  logic signed [AW-1:0]    r_acc;
  logic signed [PW-1:0]    w_prod;
  logic                    w_any, w_take;

  // Search downward so the candidate closest to r_ptr is written last and wins.
  always_comb begin
    w_gnt = '0;
    w_any = 1'b0;
    w_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      w_idx = CW'((int'(r_ptr) + i) % NCH);
      if (r_pend[w_idx]) begin
        w_gnt = w_idx;
        w_any = 1'b1;
      end
    end
    w_take = r_state == IDLE && w_any;
    for (int c = 0; c < NCH; c++) w_gnt_oh[c] = w_take && w_gnt == CW'(c);
    w_prod = PW'(r_hist[r_ch][r_k]) * PW'(COEFF[r_k]);
  end

  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_any ? LOAD : IDLE) :
             r_state == LOAD ? MAC :
             r_state == MAC  ? (r_k == KW'(N - 1) ? OUT : MAC) : IDLE;
  end

  assign o_busy = r_state != IDLE;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_pend    <= '0;
      r_smp     <= '0;
      r_ch      <= '0;
      r_ptr     <= '0;
      r_k       <= '0;
      r_acc     <= '0;
      o_valid   <= 1'b0;
      o_ch      <= '0;
      dout      <= '0;
      o_overrun <= '0;
      for (int c = 0; c < NCH; c++) begin
        r_lat[c] <= '0;
        for (int j = 0; j < N; j++) r_hist[c][j] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) if (i_trig[c]) r_lat[c] <= din[c*WIDTH +: WIDTH];
      r_pend    <= (r_pend & ~w_gnt_oh) | i_trig;
      o_overrun <= (o_overrun & {NCH{~i_clr_ovr}}) | (i_trig & r_pend & ~w_gnt_oh);
      o_valid   <= r_state == OUT;
      if (w_take) begin
        r_ch  <= w_gnt;
        r_smp <= r_lat[w_gnt];
        r_ptr <= w_gnt == CW'(NCH - 1) ? '0 : w_gnt + 1'b1;
      end
      if (r_state == LOAD) begin
        r_hist[r_ch][0] <= r_smp;
        for (int j = 1; j < N; j++) r_hist[r_ch][j] <= r_hist[r_ch][j-1];
        r_acc <= '0;
        r_k   <= '0;
      end
      if (r_state == MAC) begin
        r_acc <= r_acc + AW'(w_prod);
        r_k   <= r_k + 1'b1;
      end
      if (r_state == OUT) begin
        dout <= 32'(r_acc >>> SHIFT);
        o_ch <= r_ch;
      end
    end
  end
endmodule

// File: tb/tb_fir_tdm_scheduler.sv
// tb_fir_tdm_scheduler: directed tests with a transaction-level scheduler/FIR model checked every cycle,
// plus literal expectations for impulse, DC, contention, overrun, reset and isolation scenarios.
module tb_fir_tdm_scheduler;
  localparam int NCH = 4, N = 32, W = 14;

  logic clk = 1'b0, n_rst = 1'b1, i_clr_ovr = 1'b0;
  logic [NCH-1:0] i_trig = '0;
  logic [NCH*W-1:0] din = '0;
  logic o_busy, o_valid;
  logic [1:0] o_ch;
  logic [31:0] dout;
  logic [NCH-1:0] o_overrun;

  fir_tdm_scheduler dut (
    .clk(clk), .n_rst(n_rst), .i_trig(i_trig), .din(din), .i_clr_ovr(i_clr_ovr),
    .o_busy(o_busy), .o_valid(o_valid), .o_ch(o_ch), .dout(dout), .o_overrun(o_overrun));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cf[N];
  int m_hist[NCH][N];
  int m_lat[NCH];
  bit m_pend[NCH];
  logic [3:0] m_ovr;
  int m_ptr, edge_n = 0, free_e, busy_end;
  int q_edge[$], q_ch[$], q_val[$];
  logic [1:0] m_ch;
  logic [31:0] m_dout;
  bit m_valid;
  int ob_ch[$], ob_val[$], ob_edge[$];

  task automatic chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_lat[c] = 0;
      m_pend[c] = 0;
      for (int j = 0; j < N; j++) m_hist[c][j] = 0;
    end
    m_ovr = 0; m_ptr = 0; free_e = 0; busy_end = -1;
    m_ch = 0; m_dout = 0; m_valid = 0;
    q_edge.delete(); q_ch.delete(); q_val.delete();
  endtask

  // One job is computed whole at its grant and its result is scheduled N+2 edges later.
  task automatic model_step(logic [3:0] tr, logic [NCH*W-1:0] d, bit clr);
    int g;
    longint y;
    logic [3:0] setm;
    edge_n++;
    g = -1;
    if (edge_n >= free_e)
      for (int i = 0; i < NCH; i++) if (g < 0 && m_pend[(m_ptr + i) % NCH]) g = (m_ptr + i) % NCH;
    if (g >= 0) begin
      m_pend[g] = 0;
      m_ptr = (g + 1) % NCH;
      for (int j = N - 1; j > 0; j--) m_hist[g][j] = m_hist[g][j-1];
      m_hist[g][0] = m_lat[g];
      y = 0;
      for (int k = 0; k < N; k++) y += longint'(m_hist[g][k]) * cf[k];
      q_edge.push_back(edge_n + N + 2); q_ch.push_back(g); q_val.push_back(int'(y >>> 16));
      free_e = edge_n + N + 3;
      busy_end = edge_n + N + 2;
    end
    setm = 0;
    for (int c = 0; c < NCH; c++)
      if (tr[c]) begin
        if (m_pend[c] && c != g) setm[c] = 1'b1;
        m_lat[c] = $signed(d[c*W +: W]);
        m_pend[c] = 1;
      end
    m_ovr = (clr ? 4'b0 : m_ovr) | setm;
    m_valid = q_edge.size() > 0 && q_edge[0] == edge_n;
    if (m_valid) begin
      m_ch = 2'(q_ch.pop_front());
      m_dout = q_val.pop_front();
      void'(q_edge.pop_front());
    end
  endtask

  task automatic compare();
    chk("valid", o_valid, m_valid);
    chk("busy", o_busy, edge_n < busy_end);
    chk("overrun", o_overrun, m_ovr);
    chk("ch", o_ch, m_ch);
    chk("dout", $signed(dout), $signed(m_dout));
    if (o_valid) begin
      ob_ch.push_back(o_ch); ob_val.push_back($signed(dout)); ob_edge.push_back(edge_n);
    end
  endtask

  task automatic cyc(logic [3:0] tr, logic [NCH*W-1:0] d, bit clr);
    @(negedge clk);
    i_trig = tr; din = d; i_clr_ovr = clr;
    @(posedge clk);
    model_step(tr, d, clr);
    #1 compare();
  endtask

  task automatic idle(int n);
    repeat (n) cyc(4'b0, din, 1'b0);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    i_trig = 0; i_clr_ovr = 0; n_rst = 1'b0;
    #1 model_reset();
    compare();
    #1 n_rst = 1'b1;
  endtask

  function automatic logic [NCH*W-1:0] dv(int c, int v);
    logic [NCH*W-1:0] r = '0;
    r[c*W +: W] = W'(v);
    return r;
  endfunction

  function automatic int cnt(int base, int ch);
    int n = 0;
    for (int i = base; i < ob_ch.size(); i++) if (ob_ch[i] == ch) n++;
    return n;
  endfunction

  initial begin
    #1_000_000 $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int half[16] = '{-54, -64, -82, -97, -93, -47, 66, 266, 562, 951, 1412, 1909, 2396, 2821, 3136, 3304};
    int base, t0, nz;
    int r3[$];
    logic [NCH*W-1:0] d4;
    for (int k = 0; k < N; k++) cf[k] = k < 16 ? half[k] : half[31-k];
    #1 n_rst = 1'b0;
    #1 model_reset();
    compare();
    chk("rst_dout", $signed(dout), 0);
    chk("rst_busy", o_busy, 0);
    #1 n_rst = 1'b1;

    // impulse on ch0
    base = ob_ch.size();
    for (int t = 0; t < 33; t++) begin
      cyc(4'b0001, dv(0, t == 0 ? 1000 : 0), 1'b0);
      idle(39);
    end
    chk("t1_count", ob_ch.size() - base, 33);
    if (ob_ch.size() - base >= 33) begin
      chk("t1_k0", ob_val[base], -1);
      chk("t1_k15", ob_val[base+15], 50);
      chk("t1_after", ob_val[base+32], 0);
    end

    // DC on ch1
    base = ob_ch.size();
    for (int t = 0; t < 40; t++) begin
      cyc(4'b0010, dv(1, 8191), 1'b0);
      idle(39);
    end
    chk("t2_count", ob_ch.size() - base, 40);
    if (ob_ch.size() - base >= 40) begin
      chk("t2_32nd", ob_val[base+31], 4095);
      chk("t2_last", ob_val[base+39], 4095);
      chk("t2_ch", ob_ch[base+39], 1);
    end

    // all four channels at once after reset
    rst_pulse();
    chk("t3_rst_ch", o_ch, 0);
    base = ob_ch.size();
    d4 = dv(0, 100) | dv(1, 200) | dv(2, 300) | dv(3, 400);
    t0 = edge_n + 1;
    cyc(4'b1111, d4, 1'b0);
    idle(150);
    chk("t3_count", ob_ch.size() - base, 4);
    if (ob_ch.size() - base >= 4)
      for (int i = 0; i < 4; i++) begin
        chk("t3_lat", ob_edge[base+i] - t0, 35 * (i + 1));
        chk("t3_ch", ob_ch[base+i], i);
      end

    // overrun on ch2 while ch0 runs
    base = ob_ch.size();
    cyc(4'b0001, dv(0, 5), 1'b0);
    idle(3);
    cyc(4'b0100, dv(2, 100), 1'b0);
    idle(3);
    cyc(4'b0100, dv(2, 200), 1'b0);
    idle(1);
    chk("t4_ovr", o_overrun, 4'b0100);
    idle(80);
    chk("t4_ch2_jobs", cnt(base, 2), 1);
    for (int t = 0; t < 12; t++) begin
      cyc(4'b0100, dv(2, 0), 1'b0);
      idle(35);
    end
    cyc(4'b0000, din, 1'b1);
    chk("t4_clr", o_overrun, 4'b0000);
    cyc(4'b0001, dv(0, 0), 1'b0);
    idle(2);
    cyc(4'b1000, dv(3, 7), 1'b0);
    idle(2);
    cyc(4'b1000, dv(3, 9), 1'b1);
    chk("t4_set_wins", o_overrun, 4'b1000);
    idle(80);
    cyc(4'b0000, din, 1'b1);
    base = ob_ch.size();
    cyc(4'b0010, dv(1, 11), 1'b0);
    cyc(4'b0010, dv(1, 13), 1'b0);
    chk("t4_grant_edge_ovr", o_overrun, 4'b0000);
    idle(80);
    chk("t4_ch1_jobs", cnt(base, 1), 2);

    // reset in the middle of a ch3 job
    cyc(4'b1000, dv(3, 500), 1'b0);
    idle(12);
    chk("t5_busy_before", o_busy, 1);
    rst_pulse();
    chk("t5_valid", o_valid, 0);
    chk("t5_dout", $signed(dout), 0);
    chk("t5_busy", o_busy, 0);
    chk("t5_ovr", o_overrun, 0);
    base = ob_ch.size();
    idle(60);
    chk("t5_no_result", ob_ch.size() - base, 0);

    // impulse on ch3 interleaved with zeros on ch0
    base = ob_ch.size();
    for (int t = 0; t < 33; t++) begin
      cyc(4'b1000, dv(3, t == 0 ? 1000 : 0), 1'b0);
      idle(35);
      cyc(4'b0001, dv(0, 0), 1'b0);
      idle(35);
    end
    idle(40);
    nz = 0;
    for (int i = base; i < ob_ch.size(); i++) begin
      if (ob_ch[i] == 3) r3.push_back(ob_val[i]);
      if (ob_ch[i] == 0 && ob_val[i] != 0) nz++;
    end
    chk("t6_ch0_count", cnt(base, 0), 33);
    chk("t6_ch0_nonzero", nz, 0);
    chk("t5_ch3_count", r3.size(), 33);
    if (r3.size() >= 33) begin
      chk("t5_k0", r3[0], -1);
      chk("t5_k15", r3[15], 50);
      chk("t5_after", r3[32], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
